// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file and its read-port scheduler.
//   REG_COUNT  : number of architectural registers
//   ADDR_WIDTH : register index width
//   DATA_WIDTH : register data width
//   ZERO_REG   : index of the hard-wired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ZERO_REG   = 0;

endpackage : regfile_pkg

// File: rtl/regfile_read_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans requesters starting at
// i_ptr and wrapping modulo NUM_REQ; the first active request wins.
//   i_req       : per-requester request vector
//   i_ptr       : index with highest priority this cycle
//   i_enable    : when low no grant is produced
//   o_grant     : one-hot grant
//   o_grant_idx : index of the granted requester (0 when none)
//   o_grant_vld : a grant was produced this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_idx,
    output logic               o_grant_vld
);

    always_comb begin
        int idx;
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(i_ptr) + k) % NUM_REQ;
            // Only the first hit in scan order may claim the grant.
            if (i_enable && !o_grant_vld && i_req[IDW'(idx)]) begin
                o_grant_vld          = 1'b1;
                o_grant_idx          = IDW'(idx);
                o_grant[IDW'(idx)]   = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_read_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_read_scheduler
// Shares the register file's single read-select mux among NUM_REQ
// requesters. Two-stage valid/ready pipeline:
//   stage 1 : registered mux select (mux_select) plus owner id
//   stage 2 : captured read data (resp_data) plus owner id
//
// Ports
//   clock, reset : clock and asynchronous active-high reset
//   req_valid    : per-requester read request
//   req_addr     : packed register indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    : one-hot grant (accept = req_valid[i] & req_ready[i])
//   mux_select   : registered select driven to the external read mux
//   mux_data     : combinational read-mux output
//   resp_valid   : response available
//   resp_ready   : consumer accepts response
//   resp_id      : requester index that owns resp_data
//   resp_data    : captured register value (register 0 always reads zero)
// -----------------------------------------------------------------------------
module regfile_read_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         mux_select,
    input  logic [DATA_WIDTH-1:0]         mux_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [IDW-1:0]                resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data
);

    import regfile_pkg::*;

    // The zero register is hard-wired; ignore whatever the mux returns for it.
    function automatic logic [DATA_WIDTH-1:0] read_value(
        input logic [ADDR_WIDTH-1:0] sel,
        input logic [DATA_WIDTH-1:0] raw
    );
        return (sel == ADDR_WIDTH'(ZERO_REG)) ? '0 : raw;
    endfunction

    logic                  r_vld_p1;
    logic [ADDR_WIDTH-1:0] r_sel_p1;
    logic [IDW-1:0]        r_id_p1;
    logic [IDW-1:0]        r_ptr;
    logic                  r_vld_p2;
    logic [IDW-1:0]        r_id_p2;
    logic [DATA_WIDTH-1:0] r_data_p2;

    logic                  w_adv1;
    logic                  w_adv2;
    logic                  w_enable;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDW-1:0]        w_grant_idx;
    logic                  w_grant_vld;
    logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
    logic [IDW-1:0]        w_ptr_next;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign w_addr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign w_adv2   = !r_vld_p2 || resp_ready;
    assign w_adv1   = !r_vld_p1 || w_adv2;
    // Grant is suppressed while reset is held so req_ready reads zero.
    assign w_enable = w_adv1 && !reset;

    assign w_ptr_next = (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .i_enable    (w_enable),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // ---- stage 0 -> 1 : grant registers the select and owner ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_sel_p1 <= '0;
            r_id_p1  <= '0;
            r_ptr    <= '0;
        end else if (w_adv1) begin
            r_vld_p1 <= w_grant_vld;
            if (w_grant_vld) begin
                r_sel_p1 <= w_addr[w_grant_idx];
                r_id_p1  <= w_grant_idx;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    // ---- stage 1 -> 2 : capture mux output into the response ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_id_p2   <= '0;
            r_data_p2 <= '0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_id_p2   <= r_id_p1;
                r_data_p2 <= read_value(r_sel_p1, mux_data);
            end
        end
    end

    assign req_ready  = w_grant;
    assign mux_select = r_sel_p1;
    assign resp_valid = r_vld_p2;
    assign resp_id    = r_id_p2;
    assign resp_data  = r_data_p2;

endmodule : regfile_read_scheduler

// File: tb/tb_regfile_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_scheduler
// Table-driven directed vectors, hand-written multi-cycle sequences and
// randomized traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_regfile_read_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [4:0]  mux_select;
    logic [31:0] mux_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [31:0] resp_data;
    logic        frc;

    int total = 0;
    int bad   = 0;

    regfile_read_scheduler #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mux_select (mux_select),
        .mux_data   (mux_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    // Read-mux model: register r holds 0x1000+r unless the output is forced.
    assign mux_data = frc ? 32'hDEADBEEF : (32'h0000_1000 + {27'b0, mux_select});

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: capacity-2 in-order read queue ----------------
    typedef struct {
        int id;
        int addr;
        bit prom;   // has reached the response slot
        int data;
    } ent_t;

    ent_t mq[$];
    int   m_rr;
    int   m_sel;

    function automatic int ref_read(input int addr, input logic force_bad);
        if (addr == 0) return 0;
        return force_bad ? 32'hDEADBEEF : 32'h1000 + addr;
    endfunction

    function automatic int m_winner(input logic [3:0] rv);
        for (int k = 0; k < 4; k++) begin
            if (rv[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr  = 0;
        m_sel = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, steps the
    // model across the next rising edge, and returns at the following negedge.
    task automatic mcycle();
        logic [3:0] erdy;
        int         w;
        bit         can;
        bit         has_out;
        ent_t       e;
        #1;
        can     = (mq.size() < 2) || resp_ready;
        w       = can ? m_winner(req_valid) : -1;
        erdy    = (w >= 0) ? 4'(1 << w) : 4'b0;
        has_out = (mq.size() > 0) && mq[0].prom;
        chk("req_ready", {60'b0, req_ready}, {60'b0, erdy});
        chk("resp_valid", {63'b0, resp_valid}, {63'b0, has_out});
        chk("mux_select", {59'b0, mux_select}, 64'(m_sel));
        if (has_out) begin
            chk("resp_id", {62'b0, resp_id}, 64'(mq[0].id));
            chk("resp_data", {32'b0, resp_data}, {32'b0, 32'(mq[0].data)});
        end
        if (has_out && resp_ready) void'(mq.pop_front());
        if (mq.size() > 0 && !mq[0].prom) begin
            e      = mq[0];
            e.prom = 1'b1;
            e.data = ref_read(e.addr, frc);
            mq[0]  = e;
        end
        if (w >= 0) begin
            e.id   = w;
            e.addr = int'(req_addr[w*5 +: 5]);
            e.prom = 1'b0;
            e.data = 0;
            mq.push_back(e);
            m_rr  = (w + 1) % 4;
            m_sel = e.addr;
        end
        @(negedge clock);
    endtask

    task automatic hw_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        logic [3:0]  rv;
        logic [19:0] addr;
        bit          rr;
        bit          frc;
        logic [3:0]  e_rdy;
        bit          e_vld;
        logic [1:0]  e_id;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [19:0] a_s;
        logic [19:0] a_c;
        logic [19:0] a_z;
        logic [19:0] a_f;
        a_s = {5'd0, 5'd7, 5'd0, 5'd0};
        a_c = {5'd4, 5'd3, 5'd2, 5'd1};
        a_z = {5'd0, 5'd0, 5'd0, 5'd5};
        a_f = {5'd0, 5'd0, 5'd6, 5'd8};

        // single read from requester 2
        tbl.push_back('{1, 4'b0100, a_s, 1, 0, 4'b0100, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_s, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_s, 1, 0, 4'b0000, 1, 2'd2, 32'h1007});
        tbl.push_back('{0, 4'b0000, a_s, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        // full contention, back-to-back responses
        tbl.push_back('{1, 4'b1111, a_c, 1, 0, 4'b0001, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b1111, a_c, 1, 0, 4'b0010, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b1111, a_c, 1, 0, 4'b0100, 1, 2'd0, 32'h1001});
        tbl.push_back('{0, 4'b1111, a_c, 1, 0, 4'b1000, 1, 2'd1, 32'h1002});
        tbl.push_back('{0, 4'b1111, a_c, 1, 0, 4'b0001, 1, 2'd2, 32'h1003});
        tbl.push_back('{0, 4'b0000, a_c, 1, 0, 4'b0000, 1, 2'd3, 32'h1004});
        tbl.push_back('{0, 4'b0000, a_c, 1, 0, 4'b0000, 1, 2'd0, 32'h1001});
        tbl.push_back('{0, 4'b0000, a_c, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        // zero register with forced mux output (rr_ptr is 1 here)
        tbl.push_back('{0, 4'b0010, a_z, 1, 1, 4'b0010, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_z, 1, 1, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_z, 1, 1, 4'b0000, 1, 2'd1, 32'h0});
        // non-zero register with forced mux output; rr_ptr=2 wraps to 0
        tbl.push_back('{0, 4'b0001, a_z, 1, 1, 4'b0001, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_z, 1, 1, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_z, 1, 1, 4'b0000, 1, 2'd0, 32'hDEADBEEF});
        tbl.push_back('{0, 4'b0000, a_z, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        // fairness across idle cycles
        tbl.push_back('{1, 4'b0010, a_f, 1, 0, 4'b0010, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_f, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_f, 1, 0, 4'b0000, 1, 2'd1, 32'h1006});
        tbl.push_back('{0, 4'b0000, a_f, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0011, a_f, 1, 0, 4'b0001, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_f, 1, 0, 4'b0000, 0, 2'd0, 32'h0});
        tbl.push_back('{0, 4'b0000, a_f, 1, 0, 4'b0000, 1, 2'd0, 32'h1008});
    end

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
        resp_ready = 1'b1;
        frc        = 1'b0;
        model_reset();
        @(negedge clock);

        // reset state with requests pending
        #1;
        chk("rst_req_ready", {60'b0, req_ready}, 64'h0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'h0);
        chk("rst_resp_id", {62'b0, resp_id}, 64'h0);
        chk("rst_resp_data", {32'b0, resp_data}, 64'h0);
        chk("rst_mux_select", {59'b0, mux_select}, 64'h0);
        reset = 1'b0;
        @(negedge clock);

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            req_valid  = tbl[i].rv;
            req_addr   = tbl[i].addr;
            resp_ready = tbl[i].rr;
            frc        = tbl[i].frc;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), {60'b0, req_ready}, {60'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_resp_valid", i), {63'b0, resp_valid}, {63'b0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_resp_id", i), {62'b0, resp_id}, {62'b0, tbl[i].e_id});
                chk($sformatf("tbl%0d_resp_data", i), {32'b0, resp_data}, {32'b0, tbl[i].e_data});
            end
            @(negedge clock);
        end

        // backpressure: fill, stall five cycles, then drain in order
        frc = 1'b0;
        hw_reset();
        req_addr   = {5'd13, 5'd12, 5'd11, 5'd10};
        req_valid  = 4'b0111;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) mcycle();
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                #1;
                chk("bp_full_no_grant", {60'b0, req_ready}, 64'h0);
            end
            mcycle();
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) mcycle();

        // asynchronous reset with both stages occupied
        hw_reset();
        req_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        mcycle();
        mcycle();
        reset = 1'b1;
        #1;
        chk("async_rst_resp_valid", {63'b0, resp_valid}, 64'h0);
        chk("async_rst_mux_select", {59'b0, mux_select}, 64'h0);
        chk("async_rst_req_ready", {60'b0, req_ready}, 64'h0);
        reset = 1'b0;
        model_reset();
        req_valid  = 4'b1000;
        resp_ready = 1'b1;
        mcycle();
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) mcycle();

        // randomized traffic
        hw_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_addr   = 20'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            frc        = ($urandom_range(0, 7) == 0);
            mcycle();
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        frc        = 1'b0;
        for (int i = 0; i < 4; i++) mcycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_read_scheduler
